// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control slice: FSM encodings and
// architectural constants used by the hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DISCARD = 2'd1
    } state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [4:0]  REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: priority hazard mux, fetch-discard
// FSM after redirects, and saturating stall/flush activity counters.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 trap_i,
    input  logic                 imem_valid_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    input  logic                 cnt_clear_i,
    output logic                 pc_stall_o,
    output logic                 if_id_stall_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_stall_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_stall_o,
    output logic                 mem_wb_flush_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    state_t state;
    logic   in_discard;
    logic   mem_busy;
    logic   load_use;
    logic   flush_evt;

    assign in_discard = (state == DISCARD);
    assign mem_busy   = dmem_req_i & ~dmem_ready_i;
    assign load_use   = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                        ((id_use_rs1_i && id_rs1_i == ex_rd_i) ||
                         (id_use_rs2_i && id_rs2_i == ex_rd_i));
    // A branch blocked by a memory wait is not taken yet; it re-presents from frozen EX.
    assign flush_evt  = trap_i | (ex_branch_taken_i & ~mem_busy);

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;

        if (trap_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mem_busy) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (!in_discard && load_use) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (!in_discard && !imem_valid_i) begin
            pc_stall_o     = 1'b1;
            if_id_flush_o  = 1'b1;
        end

        // While discarding, the front end only waits for and drops the stale fetch.
        if (in_discard) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
            if_id_stall_o = 1'b0;
        end

        // NOTE: outputs are gated by the asynchronous reset so the pipeline is quiet during reset.
        if (!reset_n) begin
            pc_stall_o     = 1'b0;
            if_id_stall_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_stall_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            ex_mem_stall_o = 1'b0;
            mem_wb_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (flush_evt && !imem_valid_i) state <= DISCARD;
                DISCARD: if (imem_valid_i) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign state_o = state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pc_stall_o),
        .clr     (cnt_clear_i),
        .count   (stall_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_evt),
        .clr     (cnt_clear_i),
        .count   (flush_count_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus a
// randomized run against a row-table reference model.
module tb_pipeline_hazard_controller;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, trap;
    logic          imem_valid, dmem_req, dmem_ready, cnt_clear;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, mem_wb_flush;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;
    logic [6:0]    ctl;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_disc;
    int m_stall, m_flush;

    // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_TRAP  = 7'b0010101;
    localparam logic [6:0] C_MEM   = 7'b1101011;
    localparam logic [6:0] C_BR    = 7'b0010100;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_MISS  = 7'b1010000;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (id_use_rs1),
        .id_use_rs2_i      (id_use_rs2),
        .ex_rd_i           (ex_rd),
        .ex_mem_read_i     (ex_mem_read),
        .ex_branch_taken_i (ex_branch_taken),
        .trap_i            (trap),
        .imem_valid_i      (imem_valid),
        .dmem_req_i        (dmem_req),
        .dmem_ready_i      (dmem_ready),
        .cnt_clear_i       (cnt_clear),
        .pc_stall_o        (pc_stall),
        .if_id_stall_o     (if_id_stall),
        .if_id_flush_o     (if_id_flush),
        .id_ex_stall_o     (id_ex_stall),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_stall_o    (ex_mem_stall),
        .mem_wb_flush_o    (mem_wb_flush),
        .state_o           (state),
        .stall_count_o     (stall_count),
        .flush_count_o     (flush_count)
    );

    function automatic int model_row();
        bit lu;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (trap)                      return 1;
        if (dmem_req && !dmem_ready)   return 2;
        if (ex_branch_taken)           return 3;
        if (!m_disc && lu)             return 4;
        if (!m_disc && !imem_valid)    return 5;
        return 0;
    endfunction

    function automatic logic [6:0] model_ctl();
        logic [6:0] v;
        case (model_row())
            1:       v = C_TRAP;
            2:       v = C_MEM;
            3:       v = C_BR;
            4:       v = C_LU;
            5:       v = C_MISS;
            default: v = C_NONE;
        endcase
        if (m_disc) v = (v & 7'b0001111) | 7'b1010000;
        if (!reset_n) v = C_NONE;
        return v;
    endfunction

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        ex_branch_taken = 0; trap = 0; imem_valid = 1;
        dmem_req = 0; dmem_ready = 0; cnt_clear = 0;
    endtask

    // Advance one clock, updating the model from pre-edge inputs; returns at the next negedge.
    task automatic tick();
        logic [6:0] v;
        bit         fl;
        v  = model_ctl();
        fl = (model_row() == 1) || (model_row() == 3);
        @(posedge clk);
        if (cnt_clear) m_stall = 0; else if (v[6] && m_stall < MAXC) m_stall++;
        if (cnt_clear) m_flush = 0; else if (fl && m_flush < MAXC) m_flush++;
        m_disc = m_disc ? !imem_valid : (fl && !imem_valid);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0; set_idle();
        trap = 1; ex_branch_taken = 1; imem_valid = 0;
        m_disc = 0; m_stall = 0; m_flush = 0;
        @(negedge clk); #1;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (stall_count !== 0 || flush_count !== 0) begin n_err++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        @(negedge clk);
        reset_n = 1; set_idle();
    endtask

    task automatic test_load_use();
        set_idle();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_ctl got %b want %b", ctl, C_LU); end
        tick();
        set_idle(); #1;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL load_use_release got %b want %b", ctl, C_NONE); end
        n_cmp++; if (stall_count !== 4'd1) begin n_err++; $display("FAIL load_use_count got %0d want 1", stall_count); end
        tick();
    endtask

    task automatic test_no_false_hazard();
        set_idle();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL x0_no_stall got %b want %b", ctl, C_NONE); end
        tick();
        set_idle();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0; id_rs1 = 3; id_use_rs1 = 1;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL unused_rs2_no_stall got %b want %b", ctl, C_NONE); end
        tick();
    endtask

    task automatic test_branch_discard();
        set_idle();
        ex_branch_taken = 1; #1;
        n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL branch_ctl got %b want %b", ctl, C_BR); end
        tick();
        set_idle(); #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL branch_state got %0d want 0", state); end
        n_cmp++; if (flush_count !== CW'(m_flush)) begin n_err++;
            $display("FAIL branch_flush_count got %0d want %0d", flush_count, m_flush); end
        ex_branch_taken = 1; imem_valid = 0;
        tick();
        set_idle(); imem_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (state !== 2'd1 || ctl !== C_MISS) begin n_err++;
                $display("FAIL discard_hold[%0d] got st=%0d ctl=%b want st=1 ctl=%b", i, state, ctl, C_MISS); end
            tick();
        end
        imem_valid = 1; #1;
        n_cmp++; if (state !== 2'd1 || ctl !== C_MISS) begin n_err++;
            $display("FAIL discard_return got st=%0d ctl=%b want st=1 ctl=%b", state, ctl, C_MISS); end
        tick(); #1;
        n_cmp++; if (state !== 2'd0 || ctl !== C_NONE) begin n_err++;
            $display("FAIL discard_exit got st=%0d ctl=%b want st=0 ctl=%b", state, ctl, C_NONE); end
    endtask

    task automatic test_mem_busy();
        int f0;
        set_idle();
        dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
        f0 = m_flush;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (ctl !== C_MEM) begin n_err++; $display("FAIL mem_freeze[%0d] got %b want %b", i, ctl, C_MEM); end
            tick();
        end
        #1;
        n_cmp++; if (flush_count !== CW'(f0)) begin n_err++;
            $display("FAIL mem_deferred_flush got %0d want %0d", flush_count, f0); end
        dmem_ready = 1; #1;
        n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL mem_ready_branch got %b want %b", ctl, C_BR); end
        tick();
        set_idle(); #1;
        n_cmp++; if (flush_count !== CW'(f0 + 1)) begin n_err++;
            $display("FAIL mem_branch_flush_count got %0d want %0d", flush_count, f0 + 1); end
    endtask

    task automatic test_trap_priority();
        int f0;
        set_idle();
        trap = 1; dmem_req = 1; dmem_ready = 0;
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        f0 = m_flush;
        #1;
        n_cmp++; if (ctl !== C_TRAP) begin n_err++; $display("FAIL trap_priority got %b want %b", ctl, C_TRAP); end
        tick();
        set_idle(); #1;
        n_cmp++; if (flush_count !== CW'(f0 + 1) || state !== 2'd0) begin n_err++;
            $display("FAIL trap_after got cnt=%0d st=%0d want cnt=%0d st=0", flush_count, state, f0 + 1); end
    endtask

    task automatic test_saturation();
        set_idle(); imem_valid = 0;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_cmp++; if (stall_count !== 4'd15) begin n_err++; $display("FAIL stall_saturate got %0d want 15", stall_count); end
        cnt_clear = 1; #1;
        n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL clear_with_stall got pc_stall=%b want 1", pc_stall); end
        tick();
        set_idle(); #1;
        n_cmp++; if (stall_count !== 0 || flush_count !== 0) begin n_err++;
            $display("FAIL clear_priority got %0d/%0d want 0/0", stall_count, flush_count); end
    endtask

    task automatic test_async_reset();
        set_idle(); ex_branch_taken = 1; imem_valid = 0;
        tick();
        set_idle(); imem_valid = 0; #1;
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL pre_reset_state got %0d want 1", state); end
        #1 reset_n = 0;
        m_disc = 0; m_stall = 0; m_flush = 0;
        #1;
        n_cmp++; if (state !== 2'd0 || ctl !== C_NONE) begin n_err++;
            $display("FAIL async_reset got st=%0d ctl=%b want st=0 ctl=%b", state, ctl, C_NONE); end
        n_cmp++; if (stall_count !== 0 || flush_count !== 0) begin n_err++;
            $display("FAIL async_reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        @(negedge clk);
        reset_n = 1; set_idle();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int i = 0; i < 400; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            trap = ($urandom_range(0, 11) == 0);
            imem_valid = ($urandom_range(0, 3) != 0);
            dmem_req = 1'($urandom); dmem_ready = 1'($urandom);
            cnt_clear = ($urandom_range(0, 24) == 0);
            #1;
            exp = model_ctl();
            n_cmp++; if (ctl !== exp) begin n_err++; $display("FAIL rand_ctl[%0d] got %b want %b", i, ctl, exp); end
            n_cmp++; if (state !== {1'b0, m_disc}) begin n_err++;
                $display("FAIL rand_state[%0d] got %0d want %0d", i, state, m_disc); end
            n_cmp++; if (stall_count !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin n_err++;
                $display("FAIL rand_counts[%0d] got %0d/%0d want %0d/%0d", i, stall_count, flush_count, m_stall, m_flush); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch_discard();
        test_mem_busy();
        test_trap_priority();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
